// File: rtl/store_unit.sv
// store_unit: aligns execute-stage stores onto a 64-bit bus, flags bad stores,
// buffers legal ones and drains them in order through a request/done handshake.
`timescale 1ns/1ps
module store_unit #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_func_3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_store_addr_ma,
  output logic                  o_illegal_instr,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [7:0]            o_mem_strb,
  input  logic                  i_mem_done,
  output logic                  o_busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [7:0]            strb;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  state_t             state;
  logic               mem_valid_q;
  logic               ma_q;
  logic               ill_q;

  logic [2:0]         off;
  logic               illegal;
  logic               misaligned;
  logic               accept;
  logic               push;
  logic               pop;
  entry_t             new_entry;

  // Request decode: classification plus lane alignment of data and strobes
  always_comb begin
    off        = i_addr[2:0];
    illegal    = i_func_3[2];
    misaligned = 1'b0;
    new_entry  = '0;
    new_entry.addr = {i_addr[ADDR_WIDTH-1:3], 3'b000};
    case (i_func_3[1:0])
      2'b00: begin
        new_entry.strb = 8'(8'h01 << off);
        new_entry.data = DATA_WIDTH'(i_data[7:0]) << {off, 3'b000};
      end
      2'b01: begin
        misaligned     = off[0];
        new_entry.strb = 8'(8'h03 << off);
        new_entry.data = DATA_WIDTH'(i_data[15:0]) << {off, 3'b000};
      end
      2'b10: begin
        misaligned     = |off[1:0];
        new_entry.strb = 8'(8'h0F << off);
        new_entry.data = DATA_WIDTH'(i_data[31:0]) << {off, 3'b000};
      end
      default: begin
        misaligned     = |off;
        new_entry.strb = 8'hFF;
        new_entry.data = i_data;
      end
    endcase
  end

  assign o_req_ready = (count < CNT_W'(DEPTH));
  assign accept      = i_req_valid & o_req_ready;
  assign push        = accept & ~illegal & ~misaligned;
  assign pop         = (state == WAIT) & i_mem_done;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

  // Circular store buffer; the head entry drives the memory write port
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= new_entry;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Rejection flags: one-cycle pulse after acceptance, illegal wins over misaligned
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      ma_q  <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      ill_q <= accept & illegal;
      ma_q  <= accept & ~illegal & misaligned;
    end
  end

  // Drain FSM: one outstanding write, next request issued right after done
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state       <= IDLE;
      mem_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= REQ;
            mem_valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            state       <= WAIT;
            mem_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (i_mem_done) begin
            if (count_next != '0) begin
              state       <= REQ;
              mem_valid_q <= 1'b1;
            end else begin
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_valid     = mem_valid_q;
  assign o_mem_addr      = fifo[rd_ptr].addr;
  assign o_mem_data      = fifo[rd_ptr].data;
  assign o_mem_strb      = fifo[rd_ptr].strb;
  assign o_store_addr_ma = ma_q;
  assign o_illegal_instr = ill_q;
  assign o_busy          = (count != '0) | (state != IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios then randomized traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_store_unit;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } exp_t;

  logic        i_clk;
  logic        i_arstn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_func_3;
  logic [63:0] i_addr;
  logic [63:0] i_data;
  logic        o_store_addr_ma;
  logic        o_illegal_instr;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_data;
  logic [7:0]  o_mem_strb;
  logic        i_mem_done;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(2)) dut (
    .i_clk(i_clk), .i_arstn(i_arstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_func_3(i_func_3), .i_addr(i_addr), .i_data(i_data),
    .o_store_addr_ma(o_store_addr_ma), .o_illegal_instr(o_illegal_instr),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_strb(o_mem_strb),
    .i_mem_done(i_mem_done), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: store size from func_3, alignment by modulo, lanes by shifting
  function automatic void model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                                output logic ill, output logic ma, output exp_t e);
    int unsigned sz;
    int unsigned off;
    logic [63:0] mask;
    sz   = 1 << f[1:0];
    off  = int'(a[2:0]);
    ill  = f[2];
    ma   = !ill && ((off % sz) != 0);
    mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    e.a  = a - 64'(off);
    e.d  = (d & mask) << (8 * off);
    e.s  = 8'(((32'd1 << sz) - 32'd1) << off);
  endfunction

  // Present one request for a single edge; returns 1 time unit after that edge
  task automatic send(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
    i_req_valid = 1'b1;
    i_func_3    = f;
    i_addr      = a;
    i_data      = d;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  // Wait (bounded) for the write request, check it, then complete it
  task automatic serve(input string tag, input logic [63:0] ea, input logic [63:0] ed,
                       input logic [7:0] es);
    int n;
    n = 0;
    while (!o_mem_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(o_mem_valid), 64'd1);
    chk({tag, "_addr"}, o_mem_addr, ea);
    chk({tag, "_data"}, o_mem_data, ed);
    chk({tag, "_strb"}, 64'(o_mem_strb), 64'(es));
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    chk({tag, "_wait_valid"}, 64'(o_mem_valid), 64'd0);
    chk({tag, "_wait_busy"}, 64'(o_busy), 64'd1);
    i_mem_done = 1'b1;
    @(negedge i_clk);
    i_mem_done = 1'b0;
  endtask

  exp_t q[$];
  exp_t e;
  logic ill, ma, exp_ma, exp_ill, outstanding, acc, vld_s, rdy_s, done_s;
  int   delay, stall, n;

  initial begin
    i_arstn = 1'b0; i_req_valid = 1'b0; i_func_3 = '0; i_addr = '0; i_data = '0;
    i_mem_ready = 1'b0; i_mem_done = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 64'(o_mem_valid), 64'd0);
    chk("rst_addr", o_mem_addr, 64'd0);
    chk("rst_data", o_mem_data, 64'd0);
    chk("rst_strb", 64'(o_mem_strb), 64'd0);
    chk("rst_ma", 64'(o_store_addr_ma), 64'd0);
    chk("rst_ill", 64'(o_illegal_instr), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    i_arstn = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 64'(o_req_ready), 64'd1);

    // SB with two-cycle latency to the write request
    send(3'b000, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB);
    @(negedge i_clk);
    chk("sb_lat1_valid", 64'(o_mem_valid), 64'd0);
    chk("sb_lat1_busy", 64'(o_busy), 64'd1);
    @(negedge i_clk);
    chk("sb_lat2_valid", 64'(o_mem_valid), 64'd1);
    serve("sb", 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    chk("sb_idle_busy", 64'(o_busy), 64'd0);

    // SH then SW back to back
    send(3'b001, 64'h2006, 64'h1234);
    send(3'b010, 64'h2004, 64'hDEAD_BEEF);
    @(negedge i_clk);
    serve("sh", 64'h2000, 64'h1234_0000_0000_0000, 8'hC0);
    serve("sw", 64'h2000, 64'hDEAD_BEEF_0000_0000, 8'hF0);

    // Misaligned SD and illegal func_3 (also misaligned, illegal must win)
    send(3'b011, 64'h3004, 64'h55);
    @(negedge i_clk);
    chk("sd_ma_pulse", 64'(o_store_addr_ma), 64'd1);
    chk("sd_ma_ill", 64'(o_illegal_instr), 64'd0);
    chk("sd_ma_busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    chk("sd_ma_end", 64'(o_store_addr_ma), 64'd0);
    chk("sd_ma_novalid", 64'(o_mem_valid), 64'd0);
    send(3'b111, 64'h3001, 64'h66);
    @(negedge i_clk);
    chk("ill_pulse", 64'(o_illegal_instr), 64'd1);
    chk("ill_no_ma", 64'(o_store_addr_ma), 64'd0);
    @(negedge i_clk);
    chk("ill_end", 64'(o_illegal_instr), 64'd0);
    chk("ill_busy", 64'(o_busy), 64'd0);

    // Back-pressure: third store waits for a free entry
    chk("bp_ready0", 64'(o_req_ready), 64'd1);
    send(3'b011, 64'h4000, 64'h1111_2222_3333_4444);
    chk("bp_ready1", 64'(o_req_ready), 64'd1);
    send(3'b000, 64'h4009, 64'h77);
    chk("bp_ready2", 64'(o_req_ready), 64'd0);
    i_req_valid = 1'b1; i_func_3 = 3'b001; i_addr = 64'h400E; i_data = 64'hBEEF;
    n = 0;
    while (!o_mem_valid && n < 20) begin @(negedge i_clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(o_mem_valid), 64'd1);
      chk("hold_addr", o_mem_addr, 64'h4000);
      chk("hold_data", o_mem_data, 64'h1111_2222_3333_4444);
      chk("hold_strb", 64'(o_mem_strb), 64'hFF);
      chk("hold_ready", 64'(o_req_ready), 64'd0);
      i_mem_done = (k == 2);
      @(negedge i_clk);
    end
    i_mem_done = 1'b0;
    serve("bp_a", 64'h4000, 64'h1111_2222_3333_4444, 8'hFF);
    chk("bp_ready_free", 64'(o_req_ready), 64'd1);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    serve("bp_b", 64'h4008, 64'h0000_0000_0000_7700, 8'h02);
    serve("bp_c", 64'h4008, 64'hBEEF_0000_0000_0000, 8'hC0);
    chk("bp_busy_end", 64'(o_busy), 64'd0);

    // Reset while a write is outstanding with two entries queued
    send(3'b010, 64'h5000, 64'hAAAA_BBBB);
    send(3'b010, 64'h5004, 64'hCCCC_DDDD);
    n = 0;
    while (!o_mem_valid && n < 20) begin @(negedge i_clk); n++; end
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    chk("rw_busy", 64'(o_busy), 64'd1);
    i_arstn = 1'b0;
    #1;
    chk("rw_valid", 64'(o_mem_valid), 64'd0);
    chk("rw_addr", o_mem_addr, 64'd0);
    chk("rw_data", o_mem_data, 64'd0);
    chk("rw_strb", 64'(o_mem_strb), 64'd0);
    chk("rw_busy0", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    i_arstn = 1'b1;
    @(negedge i_clk);
    i_mem_done = 1'b1;
    @(negedge i_clk);
    i_mem_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rw_stale_valid", 64'(o_mem_valid), 64'd0);
      chk("rw_stale_busy", 64'(o_busy), 64'd0);
      @(negedge i_clk);
    end

    // Randomized traffic against the queue model
    exp_ma = 1'b0; exp_ill = 1'b0; outstanding = 1'b0; delay = 0; stall = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_ma", 64'(o_store_addr_ma), 64'(exp_ma));
      chk("rnd_ill", 64'(o_illegal_instr), 64'(exp_ill));
      chk("rnd_ready", 64'(o_req_ready), 64'(q.size() < 2));
      chk("rnd_busy", 64'(o_busy), 64'(q.size() != 0));
      if (o_mem_valid) begin
        chk("rnd_valid_outst", 64'(outstanding), 64'd0);
        chk("rnd_valid_entry", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          chk("rnd_addr", o_mem_addr, q[0].a);
          chk("rnd_data", o_mem_data, q[0].d);
          chk("rnd_strb", 64'(o_mem_strb), 64'(q[0].s));
        end
      end
      if (q.size() != 0 && !outstanding && !o_mem_valid) stall++;
      else stall = 0;
      chk("rnd_stall", 64'(stall > 1), 64'd0);

      i_req_valid = ($urandom_range(0, 9) < 6);
      n = $urandom_range(0, 9);
      i_func_3 = (n > 7) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      i_addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) i_addr[2:0] = 3'b000;
      i_data = {$urandom, $urandom};
      i_mem_ready = ($urandom_range(0, 1) == 1);
      if (outstanding) begin
        i_mem_done = (delay == 0);
        if (delay != 0) delay--;
      end else begin
        i_mem_done = ($urandom_range(0, 7) == 0);
      end
      acc    = i_req_valid && o_req_ready;
      vld_s  = o_mem_valid;
      rdy_s  = i_mem_ready;
      done_s = i_mem_done;
      model(i_func_3, i_addr, i_data, ill, ma, e);
      @(posedge i_clk);
      if (outstanding && done_s) begin
        void'(q.pop_front());
        outstanding = 1'b0;
      end
      if (vld_s && rdy_s) begin
        outstanding = 1'b1;
        delay = $urandom_range(0, 3);
      end
      if (acc && !ill && !ma) q.push_back(e);
      exp_ill = acc && ill;
      exp_ma  = acc && ma;
      @(negedge i_clk);
    end
    i_req_valid = 1'b0; i_mem_ready = 1'b0; i_mem_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
